fp_norm_round_pack: RTL
=======================

# fp_norm_round_pack

Back end of the small-float adder datapath: it takes the raw mantissa sum produced after exponent-difference alignment and the add/subtract stage, together with the selected (bigger) exponent and result sign. It performs iterative normalization (one shift per cycle), round-to-nearest-even, overflow/underflow handling and packing into the {sign, exp, frac} format. Transfers in and out use valid/ready handshakes.

## Interface
- EXP_W, 4, exponent width; bias 2^(EXP_W-1)-1; exp 0 = zero/subnormal; exp 2^EXP_W-1 (EXP_MAX) = infinity
- MAN_W, 3, stored fraction width
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  input transfer request
- in_ready  out  1  high only in IDLE
- in_sign  in  1  result sign
- in_exp  in  EXP_W  bigger exponent; must be < EXP_MAX
- in_raw  in  MAN_W+5  [MAN_W+4]=carry C, [MAN_W+3]=hidden H, [MAN_W+2:3]=frac F, [2]=guard G, [1]=round R, [0]=sticky S
- out_valid  out  1  packed result available
- out_ready  in  1  consumer accepts
- out_sign  out  1  packed sign
- out_exp  out  EXP_W  packed exponent
- out_frac  out  MAN_W  packed fraction
- flag_inexact  out  1  any of G/R/S nonzero at rounding
- flag_overflow  out  1  result rounded to infinity
- flag_underflow  out  1  out_exp==0 and inexact

## Operation
- States: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid, capture sign/exp/raw into the working registers and go to NORM. If in_exp==0, capture it as 1 (effective subnormal exponent).
- NORM evaluates one rule per cycle, in priority order:
  - C=1: shift right 1, S |= shifted-out bit, exp+1, go to ROUND.
  - raw==0: result is +0 (sign forced 0), all flags 0, go to DONE.
  - H=1: go to ROUND.
  - exp==1: set exp=0 (subnormal) with no shift, go to ROUND.
  - Otherwise: shift left 1 (zero fill), exp-1, stay in NORM.
- ROUND:
  - round_up = G & (R | S | F[0]).
  - inexact = G | R | S.
  - Add round_up to {H,F}.
  - On carry out of H: {H,F} becomes 1.000…, exp+1.
  - If exp was 0 and H becomes 1: exp=1.
  - If exp ≥ EXP_MAX after the carry shift or rounding: out_exp=EXP_MAX, frac=0, overflow=1, inexact=1.
  - Then go to DONE.
- DONE:
  - out_valid=1.
  - All outputs are registered and stable until out_ready.
  - On out_ready, go to IDLE. No acceptance in the same cycle; the next input is accepted at the earliest on the following edge.
- All exponent arithmetic is EXP_W+1 bits wide so overflow is detected; there is no wrap-around.

## Timing
- Reset (async assert, synchronous deassert path inside the flops): state=IDLE, in_ready=1, out_valid=0, out_sign/out_exp/out_frac/all flags=0.
- Latency is counted from the accept edge k.
  - Already normalized, carry, or zero input: out_valid rises after edge k+2.
  - Each left shift adds one cycle. Maximum is k+2+(MAN_W+3).
- Throughput: one result per (latency+1) cycles minimum; no overlap.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Reset asserted in any state aborts the operation immediately; the result is lost.

## Structure
- Shared package fp_pkg holds:
  - EXP_W, MAN_W, EXP_MAX, BIAS
  - the raw-field bit indices
  - a packed struct {sign, exp, frac}
  - the state enum
- One natural sub-module, fp_round_rne: combinational {H,F,G,R,S,exp} → {frac, exp, carry, inexact}, instantiated in ROUND.
- FSM and shifter stay in the top module.

## Test plan
Parameters EXP_W=4, MAN_W=3; raw is written as C_H_FFF_GRS.
- Normalized exact: exp=7, raw=0_1_010_000 -> exp 7, frac 010, no flags, out_valid after k+2.
- Carry: exp=7, raw=1_0_110_100 -> exp 8, frac 011, inexact=1.
- Left shifts: exp=5, raw=0_0_001_100 -> exp 2, frac 100, exact, out_valid after k+5.
- RNE:
  - 0_1_011_100 -> frac 100.
  - 0_1_010_100 -> frac 010.
  - exp 7, 0_1_111_110 -> exp 8, frac 000, inexact.
- Overflow: exp=14, raw=1_0_000_000 -> exp 15, frac 000, overflow=1.
- Zero, subnormal, reset:
  - raw=0, sign=1 -> +0.
  - exp=2, raw=0_0_001_000 -> exp 0, frac 010, no underflow.
  - rst_n low during NORM -> out_valid=0, in_ready=1 immediately.
  - out_ready held low in DONE -> outputs stable.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the small-float back end.
// Format parameters, raw-field layout, packed result, FSM states.
package fp_pkg;

   localparam int EXP_W = 4;
   localparam int MAN_W = 3;
   localparam int RAW_W = MAN_W + 5;
   localparam int XW    = EXP_W + 1;

   localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] BIAS =
      {1'b0, {(EXP_W-1){1'b1}}};
   localparam logic [XW-1:0] EXP_MAX_X = {1'b0, EXP_MAX};
   localparam logic [XW-1:0] EXP_ONE_X =
      {{EXP_W{1'b0}}, 1'b1};

   localparam int C_IDX = MAN_W + 4;
   localparam int H_IDX = MAN_W + 3;
   localparam int F_HI  = MAN_W + 2;
   localparam int F_LO  = 3;
   localparam int G_IDX = 2;
   localparam int R_IDX = 1;
   localparam int S_IDX = 0;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] frac;
   } fp_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_NORM,
      ST_ROUND,
      ST_DONE
   } state_t;

endpackage

// File: rtl/fp_norm_round_pack_if.sv
// Valid/ready bundle around fp_norm_round_pack.
// master = producer/consumer side, slave = the unit.
interface fp_norm_round_pack_if;
   import fp_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic             in_sign;
   logic [EXP_W-1:0] in_exp;
   logic [RAW_W-1:0] in_raw;
   logic             out_valid;
   logic             out_ready;
   logic             out_sign;
   logic [EXP_W-1:0] out_exp;
   logic [MAN_W-1:0] out_frac;
   logic             flag_inexact;
   logic             flag_overflow;
   logic             flag_underflow;

   modport master (
      output in_valid, in_sign, in_exp, in_raw,
      output out_ready,
      input  in_ready, out_valid,
      input  out_sign, out_exp, out_frac,
      input  flag_inexact, flag_overflow,
      input  flag_underflow
   );

   modport slave (
      input  in_valid, in_sign, in_exp, in_raw,
      input  out_ready,
      output in_ready, out_valid,
      output out_sign, out_exp, out_frac,
      output flag_inexact, flag_overflow,
      output flag_underflow
   );

endinterface

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized {H,F,G,R,S}.
// Handles carry renormalize, subnormal promote, overflow.
module fp_round_rne
   import fp_pkg::*;
(
   input  logic             h,
   input  logic [MAN_W-1:0] f,
   input  logic             g,
   input  logic             r,
   input  logic             s,
   input  logic [XW-1:0]    exp_in,
   output logic [MAN_W-1:0] frac_out,
   output logic [EXP_W-1:0] exp_out,
   output logic             inexact,
   output logic             overflow
);

   logic             round_up;
   logic             carry;
   logic [MAN_W+1:0] sum;
   logic [XW-1:0]    exp_n;

   // rounding increment, renormalize and saturate
   always_comb begin
      round_up = g & (r | s | f[0]);
      sum      = {1'b0, h, f}
               + {{(MAN_W+1){1'b0}}, round_up};
      carry    = sum[MAN_W+1];
      exp_n    = exp_in;
      frac_out = sum[MAN_W-1:0];
      if (carry) begin
         exp_n    = exp_in + EXP_ONE_X;
         frac_out = '0;
      end else if (exp_in == '0 && sum[MAN_W]) begin
         exp_n = EXP_ONE_X;
      end
      overflow = (exp_n >= EXP_MAX_X);
      inexact  = g | r | s | overflow;
      exp_out  = exp_n[EXP_W-1:0];
      if (overflow) begin
         exp_out  = EXP_MAX;
         frac_out = '0;
      end
   end

endmodule

// File: rtl/fp_norm_round_pack.sv
// Normalize (one shift per cycle), round RNE and pack.
// Single registered FSM; all outputs come from flops.
module fp_norm_round_pack
   import fp_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   fp_norm_round_pack_if.slave  bus
);

   state_t           state;
   logic             sign_q;
   logic [XW-1:0]    exp_q;
   logic [RAW_W-1:0] raw_q;
   fp_t              res_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             inexact_q;
   logic             ovf_q;
   logic             unf_q;

   logic [RAW_W-1:0] raw_shr;
   logic [RAW_W-1:0] raw_shl;
   logic [MAN_W-1:0] rnd_frac;
   logic [EXP_W-1:0] rnd_exp;
   logic             rnd_inexact;
   logic             rnd_ovf;

   assign raw_shr = {1'b0, raw_q[RAW_W-1:2],
                     raw_q[R_IDX] | raw_q[S_IDX]};
   assign raw_shl = {raw_q[RAW_W-2:0], 1'b0};

   fp_round_rne u_rnd (
      .h        (raw_q[H_IDX]),
      .f        (raw_q[F_HI:F_LO]),
      .g        (raw_q[G_IDX]),
      .r        (raw_q[R_IDX]),
      .s        (raw_q[S_IDX]),
      .exp_in   (exp_q),
      .frac_out (rnd_frac),
      .exp_out  (rnd_exp),
      .inexact  (rnd_inexact),
      .overflow (rnd_ovf)
   );

   // control FSM, working registers and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         sign_q      <= 1'b0;
         exp_q       <= '0;
         raw_q       <= '0;
         res_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         inexact_q   <= 1'b0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  sign_q     <= bus.in_sign;
                  exp_q      <= (bus.in_exp == '0)
                              ? EXP_ONE_X
                              : {1'b0, bus.in_exp};
                  raw_q      <= bus.in_raw;
                  in_ready_q <= 1'b0;
                  state      <= ST_NORM;
               end
            end
            ST_NORM: begin
               if (raw_q[C_IDX]) begin
                  raw_q <= raw_shr;
                  exp_q <= exp_q + EXP_ONE_X;
                  state <= ST_ROUND;
               end else if (raw_q == '0) begin
                  // zero passes through ROUND as +0
                  // so it keeps the 2-cycle latency
                  sign_q <= 1'b0;
                  exp_q  <= '0;
                  state  <= ST_ROUND;
               end else if (raw_q[H_IDX]) begin
                  state <= ST_ROUND;
               end else if (exp_q == EXP_ONE_X) begin
                  exp_q <= '0;
                  state <= ST_ROUND;
               end else begin
                  raw_q <= raw_shl;
                  exp_q <= exp_q - EXP_ONE_X;
               end
            end
            ST_ROUND: begin
               res_q.sign  <= sign_q;
               res_q.exp   <= rnd_exp;
               res_q.frac  <= rnd_frac;
               inexact_q   <= rnd_inexact;
               ovf_q       <= rnd_ovf;
               unf_q       <= (rnd_exp == '0)
                            && rnd_inexact;
               out_valid_q <= 1'b1;
               state       <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_sign       = res_q.sign;
   assign bus.out_exp        = res_q.exp;
   assign bus.out_frac       = res_q.frac;
   assign bus.flag_inexact   = inexact_q;
   assign bus.flag_overflow  = ovf_q;
   assign bus.flag_underflow = unf_q;

endmodule
